imm_enc: RTL and testbench
==========================

IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 Parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1  field set on inputs is valid.
REQ-005 in_ready  out  1  encoder can accept a field set this cycle.
REQ-006 fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-007 opcode  in  7  instruction bits [6:0].
REQ-008 rd, rs1, rs2  in  5 each  register fields.
REQ-009 funct3  in  3; funct7  in  7  function fields.
REQ-010 imm  in  32  byte-offset or value immediate, two's complement.
REQ-011 out_valid  out  1  out_instr/out_err hold a valid entry.
REQ-012 out_ready  in  1  consumer accepts the entry this cycle.
REQ-013 out_instr  out  32  encoded RV32I instruction word.
REQ-014 out_err  out  1  entry's immediate or fmt was unrepresentable.
REQ-015 err_seen  out  1  sticky; set by any accepted entry with error.
REQ-016 count  out  CNT_W  number of output handshakes, modulo 2^CNT_W.

Function
REQ-017 Input handshake: accept when in_valid & in_ready; output handshake: pop when out_valid & out_ready.
REQ-018 A 2-entry FIFO holds encoded words plus error bits; in_ready = (occupancy < 2), out_valid = (occupancy > 0), both decoded from registered state only.
REQ-019 Latency: an entry accepted in cycle N is visible on out_instr in cycle N+1 if the FIFO was empty.
REQ-020 Push and pop in the same cycle leave occupancy unchanged and preserve order; when full, no push occurs regardless of in_valid.
REQ-021 R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored, never an error.
REQ-022 I: {imm[11:0], rs1, funct3, rd, opcode}; error unless imm[31:11] all equal.
REQ-023 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; error unless imm[31:11] all equal.
REQ-024 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; error unless imm[0]=0 and imm[31:12] all equal.
REQ-025 U: {imm[31:12], rd, opcode}; error unless imm[11:0]=0.
REQ-026 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; error unless imm[0]=0 and imm[31:20] all equal.
REQ-027 fmt 6/7: out_instr = 0, out_err = 1.
REQ-028 Erroneous entries are still encoded (truncated fields) and passed through in order with out_err = 1.
REQ-029 err_seen sets the cycle after accepting an error entry and stays set until reset.
REQ-030 count increments by 1 on each output handshake and wraps from all-ones to 0.
REQ-031 out_instr/out_err hold stable while out_valid & ~out_ready.

Reset
REQ-032 resetn low: occupancy 0, in_ready 1, out_valid 0, out_instr 0, out_err 0, err_seen 0, count 0, immediately and asynchronously.
REQ-033 Reset during a transfer discards all FIFO contents; the first accept after release starts a fresh stream.

Verification
REQ-034 fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_instr=0x00500093, out_err=0.
REQ-035 fmt=2, opcode=0x23, rs1=3, rs2=2, funct3=2, imm=4 -> 0x0021A223; fmt=5, opcode=0x6F, rd=1, imm=8 -> 0x008000EF.
REQ-036 fmt=4, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7; same with imm=0x12345001 -> out_err=1, err_seen=1.
REQ-037 fmt=1, imm=2048 -> out_err=1; fmt=3, imm=-4 -> out_instr[31]=1, out_err=0; fmt=7 -> out_instr=0, out_err=1.
REQ-038 out_ready=0, in_valid=1 for 4 cycles -> exactly 2 accepted, in_ready=0 from cycle 2, words held stable; out_ready=1 then drains in order, count=2.
REQ-039 Reset asserted with 2 entries queued -> out_valid=0, count=0 at once; CNT_W=2 with 5 pops -> count=1.

Source files
------------

// File: rtl/imm_enc.sv
// RV32I instruction encoder: packs register/function fields and an immediate
// into a 32-bit word per format, flags unrepresentable immediates, and queues results in a 2-entry FIFO.
`timescale 1ns/1ps
module imm_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             err_seen,
  output logic [CNT_W-1:0] count
);

  // Returns {err, word}; erroneous immediates are still encoded from their low bits.
  function automatic logic [32:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    logic        e;
    w = '0;
    e = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin
        w = {im[11:0], s1, f3, d, op};
        e = (im[31:11] != {21{im[11]}});
      end
      3'd2: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = (im[31:11] != {21{im[11]}});
      end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = im[0] | (im[31:12] != {20{im[12]}});
      end
      3'd4: begin
        w = {im[31:12], d, op};
        e = |im[11:0];
      end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = im[0] | (im[31:20] != {12{im[20]}});
      end
      default: begin
        w = '0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  logic [32:0]      mem_q [0:1];
  logic [32:0]      mem_d [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             err_seen_q, err_seen_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [32:0]      enc;
  logic [32:0]      head;
  logic             push, pop;

  assign enc       = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign in_ready  = ~occ_q[1];
  assign out_valid = |occ_q;
  assign head      = mem_q[rd_ptr_q];
  // Storage is not reset; gating by out_valid gives zero outputs when empty.
  assign out_instr = out_valid ? head[31:0] : 32'd0;
  assign out_err   = out_valid & head[32];
  assign err_seen  = err_seen_q;
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = occ_q;
    err_seen_d = err_seen_q | (push & enc[32]);
    count_d    = count_q + {{(CNT_W-1){1'b0}}, pop};
    if (push) begin
      mem_d[wr_ptr_q] = enc;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      err_seen_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      err_seen_q <= err_seen_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

endmodule

// File: tb/tb_imm_enc.sv
// Directed + random scoreboard bench for imm_enc; a second instance with CNT_W=2
// shares all inputs to exercise counter wrap.
`timescale 1ns/1ps
module tb_imm_enc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_instr, out_instr2;
  logic        out_err, out_err2;
  logic        err_seen, err_seen2;
  logic [15:0] count;
  logic [1:0]  count2;

  imm_enc #(.CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_seen(err_seen), .count(count)
  );

  imm_enc #(.CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_err(out_err2), .err_seen(err_seen2), .count(count2)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] sbq[$];
  logic [15:0] exp_count;
  logic        exp_err_seen;
  logic        last_acc;
  int          n_dut_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from bit positions and signed range limits.
  function automatic logic [32:0] model(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] im
  );
    logic [31:0]        w;
    logic               e;
    logic signed [31:0] s;
    s = im;
    w = 32'd0;
    e = 1'b0;
    case (f)
      3'd0: begin
        w[6:0] = op; w[11:7] = d; w[14:12] = f3; w[19:15] = s1;
        w[24:20] = s2; w[31:25] = f7;
      end
      3'd1: begin
        w[6:0] = op; w[11:7] = d; w[14:12] = f3; w[19:15] = s1;
        w[31:20] = s[11:0];
        e = (s < -32'sd2048) || (s > 32'sd2047);
      end
      3'd2: begin
        w[6:0] = op; w[11:7] = s[4:0]; w[14:12] = f3; w[19:15] = s1;
        w[24:20] = s2; w[31:25] = s[11:5];
        e = (s < -32'sd2048) || (s > 32'sd2047);
      end
      3'd3: begin
        w[6:0] = op; w[7] = s[11]; w[11:8] = s[4:1]; w[14:12] = f3;
        w[19:15] = s1; w[24:20] = s2; w[30:25] = s[10:5]; w[31] = s[12];
        e = s[0] || (s < -32'sd4096) || (s > 32'sd4095);
      end
      3'd4: begin
        w[6:0] = op; w[11:7] = d; w[31:12] = s[31:12];
        e = (s[11:0] != 12'd0);
      end
      3'd5: begin
        w[6:0] = op; w[11:7] = d; w[19:12] = s[19:12]; w[20] = s[11];
        w[30:21] = s[10:1]; w[31] = s[20];
        e = s[0] || (s < -32'sd1048576) || (s > 32'sd1048575);
      end
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  // One clock: check state at the falling edge, update the scoreboard, advance.
  task automatic tick();
    logic [32:0] front;
    logic        exp_push, exp_pop;
    @(negedge clk);
    chk("in_ready", in_ready, sbq.size() < 2);
    chk("out_valid", out_valid, sbq.size() > 0);
    chk("count", count, exp_count);
    chk("count2", count2, exp_count[1:0]);
    chk("err_seen", err_seen, exp_err_seen);
    exp_pop  = out_ready && (sbq.size() > 0);
    exp_push = in_valid && (sbq.size() < 2);
    if (in_valid && in_ready) n_dut_acc++;
    if (sbq.size() > 0) begin
      front = sbq[0];
      chk("out_instr", out_instr, front[31:0]);
      chk("out_err", out_err, front[32]);
    end
    if (exp_pop) begin
      void'(sbq.pop_front());
      exp_count++;
    end
    if (exp_push) begin
      front = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      sbq.push_back(front);
      if (front[32]) exp_err_seen = 1'b1;
    end
    last_acc = exp_push;
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] im
  );
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic randomize_fields();
    logic [31:0] r;
    r      = $urandom;
    fmt    = 3'($urandom_range(0, 7));
    opcode = r[6:0];
    rd     = r[11:7];
    rs1    = r[16:12];
    rs2    = r[21:17];
    funct3 = r[24:22];
    funct7 = r[31:25];
    r      = $urandom;
    case ($urandom_range(0, 3))
      0:       imm = r;
      1:       imm = {{21{r[11]}}, r[10:0]};
      2:       imm = r & 32'hFFFF_F000;
      default: imm = {{19{r[12]}}, r[12:1], 1'b0};
    endcase
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    exp_count = 16'd0; exp_err_seen = 1'b0; last_acc = 1'b0; n_dut_acc = 0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_err_seen", err_seen, 1'b0);
    chk("rst_count", count, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reference vectors
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("i_addi_instr", out_instr, 32'h0050_0093);
    chk("i_addi_err", out_err, 1'b0);
    tick();
    send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd4);
    chk("s_sw_instr", out_instr, 32'h0021_A223);
    tick();
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk("j_jal_instr", out_instr, 32'h0080_00EF);
    tick();
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    chk("u_lui_instr", out_instr, 32'h1234_52B7);
    chk("u_lui_err", out_err, 1'b0);
    chk("u_lui_sticky", err_seen, 1'b0);
    tick();
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    chk("u_bad_err", out_err, 1'b1);
    chk("u_bad_sticky", err_seen, 1'b1);
    tick();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("i_2048_err", out_err, 1'b1);
    tick();
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("b_neg_sign", out_instr[31], 1'b1);
    chk("b_neg_err", out_err, 1'b0);
    tick();
    send(3'd7, 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'd0);
    chk("fmt7_instr", out_instr, 32'd0);
    chk("fmt7_err", out_err, 1'b1);
    tick();

    // Immediate range edges, checked through the scoreboard
    send(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    send(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2047);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd4094);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd4096);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd6);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    send(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'hDEAD_BEEF);
    tick();
    tick();

    // Backpressure: consumer stalled while producer keeps offering
    out_ready = 1'b0;
    n_dut_acc = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_fields();
      tick();
    end
    chk("bp_accepted", n_dut_acc, 2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_drained", out_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      randomize_fields();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset with two entries queued
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4000);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_count", count, 16'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_err_seen", err_seen, 1'b0);
    sbq.delete();
    exp_count    = 16'd0;
    exp_err_seen = 1'b0;
    @(negedge clk);
    #2;
    resetn    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("fresh_instr", out_instr, 32'h0031_00B3);
    for (int i = 0; i < 4; i++) begin
      send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3));
    end
    tick();
    tick();
    chk("cnt2_wrap", count2, 2'd1);
    chk("cnt16_five", count, 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
